icache_refill_ctrl: RTL

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_refill_ctrl_if.sv | 27 ++
 rtl/icache_refill_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg
// Shared constants for the I-cache refill controller: FSM state encodings and
// the fixed AXI burst attributes used for every line refill.
package icache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ADDR   = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_COMMIT = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_64    = 3'b011;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if
// AXI read-address and read-data channels between the refill controller
// (master) and the memory side (slave).
//   ar_valid/ar_ready/ar_addr/ar_len/ar_burst/ar_size : read-address channel
//   r_valid/r_ready/r_data/r_last                      : read-data channel
interface icache_refill_ctrl_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [1:0]  ar_burst;
  logic [2:0]  ar_size;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic        r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_burst, ar_size, r_ready,
    input  ar_ready, r_valid, r_data, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_burst, ar_size, r_ready,
    output ar_ready, r_valid, r_data, r_last
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
// Refills one I-cache line on a fetch miss: invalidates the victim way,
// issues one AXI INCR burst of B 64-bit words, streams the beats into the line
// data array and finally writes the tag as valid (or invalid if the burst's
// r_last framing was wrong).
// Ports:
//   clk, reset                    : clock, async active-high reset
//   axi (master)                  : AXI read-address / read-data channels
//   miss_req, miss_addr, lru_way  : miss request, sampled only in IDLE
//   fill_we/set/way/word/data     : line data write port
//   tag_we, tag_valid, tag_value  : tag/valid write for fill_set/fill_way
//   busy, done, err               : status; err pulses on an r_last mismatch
//
// state  | meaning
// IDLE   | waiting for miss_req
// ADDR   | AR request outstanding; first cycle also invalidates the victim
// DATA   | accepting B read beats into the line
// COMMIT | tag write (valid unless a framing mismatch was seen)
// DONE   | one-cycle done pulse
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int B = 8,
  parameter int s = 6,
  parameter int b = 3,
  parameter int y = 3,
  parameter int t = 64 - s - b - y
) (
  input  logic                 clk,
  input  logic                 reset,
  icache_refill_ctrl_if.master axi,
  input  logic                 miss_req,
  input  logic [63:0]          miss_addr,
  input  logic                 lru_way,
  output logic                 fill_we,
  output logic [s-1:0]         fill_set,
  output logic                 fill_way,
  output logic [b-1:0]         fill_word,
  output logic [63:0]          fill_data,
  output logic                 tag_we,
  output logic                 tag_valid,
  output logic [t-1:0]         tag_value,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t         state;
  logic [63:0]    addr_q;
  logic           way_q;
  logic [b-1:0]   beat_q;
  logic           mism_q;
  logic           first_q;

  logic in_addr, in_data, in_commit;
  logic beat, last_beat, frame_err;

  assign in_addr   = (state == ST_ADDR);
  assign in_data   = (state == ST_DATA);
  assign in_commit = (state == ST_COMMIT);

  // r_ready is simply "in DATA", so an accepted beat is r_valid in DATA.
  assign beat      = in_data && axi.r_valid;
  assign last_beat = (beat_q == b'(B - 1));
  assign frame_err = beat && (axi.r_last != last_beat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      way_q   <= 1'b0;
      beat_q  <= '0;
      mism_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_req) begin
            addr_q  <= {miss_addr[63:b+y], {(b+y){1'b0}}};
            way_q   <= lru_way;
            beat_q  <= '0;
            mism_q  <= 1'b0;
            first_q <= 1'b1;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          first_q <= 1'b0;
          if (axi.ar_ready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat) begin
            beat_q <= beat_q + 1'b1;
            if (frame_err) mism_q <= 1'b1;
            // Framing errors never shorten the burst: B beats are always taken.
            if (last_beat) state <= ST_COMMIT;
          end
        end
        ST_COMMIT: state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    axi.ar_valid = in_addr;
    axi.ar_addr  = in_addr ? addr_q : '0;
    axi.ar_len   = in_addr ? 8'(B - 1) : '0;
    axi.ar_burst = in_addr ? AXI_BURST_INCR : '0;
    axi.ar_size  = in_addr ? AXI_SIZE_64 : '0;
    axi.r_ready  = in_data;

    fill_we   = beat;
    fill_word = beat ? beat_q : '0;
    fill_data = beat ? axi.r_data : '0;

    // Victim is invalidated on ADDR entry, before any data word lands.
    tag_we    = (in_addr && first_q) || in_commit;
    tag_valid = in_commit && !mism_q;
    tag_value = tag_we ? addr_q[63 -: t] : '0;

    // Set/way address both the data write and the tag write.
    fill_set  = (fill_we || tag_we) ? addr_q[b+y +: s] : '0;
    fill_way  = (fill_we || tag_we) ? way_q : 1'b0;

    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    err  = frame_err;
  end

endmodule
